// File: rtl/matrix_multiply_unit_pkg.sv
// Default dimensions shared by the systolic matrix multiply unit and its processing elements.
// Only the default constants live here; every instance can override them through parameters.
package matrix_multiply_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH             = 8;
  localparam int unsigned DEFAULT_LENGTH            = 3;
  localparam int unsigned DEFAULT_ACCUMULATOR_WIDTH = 32;

endpackage : matrix_multiply_unit_pkg

// File: rtl/matrix_multiply_unit_processing_element.sv
// One output-stationary MAC cell: registers its a/b operands for its right/lower neighbours
// and accumulates their unsigned product into a wrapping accumulator.
module processing_element
  import matrix_multiply_unit_pkg::*;
#(
  parameter int unsigned WIDTH             = DEFAULT_WIDTH,
  parameter int unsigned ACCUMULATOR_WIDTH = DEFAULT_ACCUMULATOR_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_async_rst,
  input  logic                         i_sync_rst,
  input  logic                         i_en,
  input  logic [WIDTH-1:0]             i_a,
  input  logic [WIDTH-1:0]             i_b,
  output logic [WIDTH-1:0]             o_a,
  output logic [WIDTH-1:0]             o_b,
  output logic [ACCUMULATOR_WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0]           w_product;
  logic [ACCUMULATOR_WIDTH-1:0] w_product_ext;
  logic [WIDTH-1:0]             r_a;
  logic [WIDTH-1:0]             r_b;
  logic [ACCUMULATOR_WIDTH-1:0] r_acc;

  // Operands are widened before the multiply so the full 2*WIDTH product is kept.
  assign w_product     = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign w_product_ext = ACCUMULATOR_WIDTH'(w_product);

  // NOTE: every register here is reset (async and sync) so no stale partial sum or
  // in-flight operand survives a restart; state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_sync_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= r_acc + w_product_ext;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule : processing_element

// File: rtl/matrix_multiply_unit.sv
// LENGTH x LENGTH output-stationary systolic array: activations flow right, weights flow down,
// and each cell's accumulator is exposed directly as one element of the product matrix.
module matrix_multiply_unit
  import matrix_multiply_unit_pkg::*;
#(
  parameter int unsigned WIDTH             = DEFAULT_WIDTH,
  parameter int unsigned LENGTH            = DEFAULT_LENGTH,
  parameter int unsigned ACCUMULATOR_WIDTH = DEFAULT_ACCUMULATOR_WIDTH
) (
  input  logic                         CLK,
  input  logic                         ASYNC_RST,
  input  logic                         SYNC_RST,
  input  logic                         EN,
  input  logic [WIDTH-1:0]             Inputs  [LENGTH],
  input  logic [WIDTH-1:0]             Weights [LENGTH],
  output logic [ACCUMULATOR_WIDTH-1:0] Result  [LENGTH][LENGTH]
);

  logic [WIDTH-1:0] w_a_in  [LENGTH][LENGTH];
  logic [WIDTH-1:0] w_b_in  [LENGTH][LENGTH];
  logic [WIDTH-1:0] w_a_out [LENGTH][LENGTH];
  logic [WIDTH-1:0] w_b_out [LENGTH][LENGTH];

  for (genvar row = 0; row < LENGTH; row++) begin : g_row
    for (genvar col = 0; col < LENGTH; col++) begin : g_col
      // Edge cells take the external feed; interior cells take their neighbour's register.
      if (col == 0) begin : g_a_edge
        assign w_a_in[row][col] = Inputs[row];
      end else begin : g_a_chain
        assign w_a_in[row][col] = w_a_out[row][col-1];
      end

      if (row == 0) begin : g_b_edge
        assign w_b_in[row][col] = Weights[col];
      end else begin : g_b_chain
        assign w_b_in[row][col] = w_b_out[row-1][col];
      end

      processing_element #(
        .WIDTH             (WIDTH),
        .ACCUMULATOR_WIDTH (ACCUMULATOR_WIDTH)
      ) u_pe (
        .i_clk       (CLK),
        .i_async_rst (ASYNC_RST),
        .i_sync_rst  (SYNC_RST),
        .i_en        (EN),
        .i_a         (w_a_in[row][col]),
        .i_b         (w_b_in[row][col]),
        .o_a         (w_a_out[row][col]),
        .o_b         (w_b_out[row][col]),
        .o_acc       (Result[row][col])
      );
    end
  end

endmodule : matrix_multiply_unit

// File: tb/tb_matrix_multiply_unit.sv
// Scoreboard bench for the 3x3 systolic matrix multiply unit, plus a narrow-accumulator
// instance that makes modular wrap observable within a short run.
module tb_matrix_multiply_unit;

  localparam int W     = 8;
  localparam int L     = 3;
  localparam int ACC   = 32;
  localparam int ACC_N = 20;

  typedef int unsigned mat_t [L][L];

  logic             clk = 1'b0;
  logic             async_rst;
  logic             sync_rst;
  logic             en;
  logic [W-1:0]     inputs   [L];
  logic [W-1:0]     weights  [L];
  logic [ACC-1:0]   result   [L][L];
  logic [ACC_N-1:0] result_n [L][L];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mat_t a_t2  = '{'{4, 3, 7}, '{4, 4, 7}, '{6, 8, 2}};
  mat_t b_t2  = '{'{9, 4, 5}, '{10, 4, 5}, '{7, 4, 7}};
  mat_t c_t2  = '{'{115, 56, 84}, '{125, 60, 89}, '{148, 64, 84}};
  mat_t a_id  = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
  mat_t m_max = '{'{255, 255, 255}, '{255, 255, 255}, '{255, 255, 255}};

  matrix_multiply_unit #(.WIDTH(W), .LENGTH(L), .ACCUMULATOR_WIDTH(ACC)) dut (
    .CLK(clk), .ASYNC_RST(async_rst), .SYNC_RST(sync_rst), .EN(en),
    .Inputs(inputs), .Weights(weights), .Result(result)
  );

  matrix_multiply_unit #(.WIDTH(W), .LENGTH(L), .ACCUMULATOR_WIDTH(ACC_N)) dut_narrow (
    .CLK(clk), .ASYNC_RST(async_rst), .SYNC_RST(sync_rst), .EN(en),
    .Inputs(inputs), .Weights(weights), .Result(result_n)
  );

  always #5 clk = ~clk;

  // Sum of the products that have reached PE(i,j) by edge e of a stream.
  function automatic longint unsigned partial(mat_t a, mat_t b, int e, int i, int j);
    longint unsigned s = 0;
    for (int k = 0; k < L; k++)
      if (i + j + k + 1 <= e) s += longint'(a[i][k]) * longint'(b[k][j]);
    return s;
  endfunction

  task automatic push_model(mat_t a, mat_t b, int e, int bits);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++)
        exp_q.push_back(32'(partial(a, b, e, i, j) % (64'd1 << bits)));
  endtask

  task automatic push_matrix(mat_t m);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) exp_q.push_back(m[i][j]);
  endtask

  task automatic push_const(longint unsigned v, int bits);
    for (int n = 0; n < L * L; n++) exp_q.push_back(32'(v % (64'd1 << bits)));
  endtask

  // An empty scoreboard yields X, which can never match a driven result.
  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_step(mat_t a, mat_t b, int s);
    for (int r = 0; r < L; r++) begin
      inputs[r]  = (s - r - 1 >= 0 && s - r - 1 < L) ? W'(a[r][s-r-1]) : '0;
      weights[r] = (s - r - 1 >= 0 && s - r - 1 < L) ? W'(b[s-r-1][r]) : '0;
    end
  endtask

  task automatic feed_stream(mat_t a, mat_t b, int edges);
    for (int s = 1; s <= edges; s++) begin
      drive_step(a, b, s);
      tick();
    end
    drive_step(a, b, 0);
  endtask

  task automatic sync_clear();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    #2;
    async_rst = 1'b1;
    #1;
    push_const(0, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL reset_immediate[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
    #1;
    async_rst = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    push_const(0, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL reset_hold[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    feed_stream(a_t2, b_t2, 7);
    push_matrix(c_t2);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL stream_edge7[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
    repeat (3) tick();
    push_matrix(c_t2);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL stream_hold[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    sync_clear();
    for (int s = 1; s <= 2; s++) begin
      drive_step(a_t2, b_t2, s);
      tick();
    end
    drive_step(a_t2, b_t2, 3);
    en = 1'b0;
    repeat (2) tick();
    push_model(a_t2, b_t2, 2, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL stall_frozen[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
    en = 1'b1;
    for (int s = 3; s <= 7; s++) begin
      drive_step(a_t2, b_t2, s);
      tick();
    end
    push_matrix(c_t2);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL stall_final[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
  endtask

  task automatic test_sync_reset();
    logic [31:0] e;
    sync_clear();
    push_const(0, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL sync_clear[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
    feed_stream(a_t2, b_t2, 7);
    en = 1'b0;
    sync_clear();
    en = 1'b1;
    push_const(0, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL sync_clear_en0[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
  endtask

  task automatic test_async_mid();
    logic [31:0] e;
    feed_stream(a_t2, b_t2, 3);
    #2;
    async_rst = 1'b1;
    #1;
    push_const(0, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL async_mid[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
    #1;
    async_rst = 1'b0;
    repeat (6) tick();
    push_const(0, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL async_discard[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    longint unsigned per_stream = 3 * 255 * 255;
    sync_clear();
    for (int n = 1; n <= 6; n++) begin
      feed_stream(m_max, m_max, 7);
      if (n == 1 || n == 6) begin
        push_const(per_stream * longint'(n), ACC);
        push_const(per_stream * longint'(n), ACC_N);
        for (int i = 0; i < L; i++)
          for (int j = 0; j < L; j++) begin
            e = pop_exp(); checks++;
            if (result[i][j] !== e) begin
              errors++; $display("FAIL overflow_acc32_s%0d[%0d][%0d]: got %0d want %0d", n, i, j, result[i][j], e);
            end
          end
        for (int i = 0; i < L; i++)
          for (int j = 0; j < L; j++) begin
            e = pop_exp(); checks++;
            if (result_n[i][j] !== e[ACC_N-1:0]) begin
              errors++; $display("FAIL overflow_wrap_s%0d[%0d][%0d]: got %0d want %0d", n, i, j, result_n[i][j], e[ACC_N-1:0]);
            end
          end
      end
    end
  endtask

  task automatic test_identity();
    logic [31:0] e;
    sync_clear();
    feed_stream(a_id, b_t2, 6);
    push_model(a_id, b_t2, 6, ACC);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL identity_edge6[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
    tick();
    push_matrix(b_t2);
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) begin
        e = pop_exp(); checks++;
        if (result[i][j] !== e) begin
          errors++; $display("FAIL identity_edge7[%0d][%0d]: got %0d want %0d", i, j, result[i][j], e);
        end
      end
  endtask

  initial begin
    async_rst = 1'b0;
    sync_rst  = 1'b0;
    en        = 1'b0;
    for (int r = 0; r < L; r++) begin
      inputs[r]  = '0;
      weights[r] = '0;
    end
    test_reset();
    test_stream();
    test_stall();
    test_sync_reset();
    test_async_mid();
    test_overflow();
    test_identity();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_matrix_multiply_unit
